// File: rtl/dmi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmi_xfer_ctrl
// Purpose  : DMI transaction controller between the JTAG DTM "dmi" data
//            register and the RISC-V Debug Module. Each Update-DR becomes a
//            valid/ready request to the DM, and the response is collected.
//            The controller keeps the sticky dmistat error and supplies the
//            value loaded into "dmi" on Capture-DR.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro : DMI_XFER_TIMEOUT_EN
//   Defined   -> a transaction is aborted after TIMEOUT_CYCLES in REQ/WAIT.
//   Undefined -> the FSM waits indefinitely for the DM.
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   dtm_update_i        : Update-DR pulse carrying dtm_addr_i/data_i/op_i
//   dmireset_i          : clears the sticky error
//   dmihardreset_i      : aborts the transaction, clears all state
//   capture_*_o         : address / read data / status for Capture-DR
//   dmistat_o           : sticky error
//   busy_o              : transaction in flight
//   dmi_req_*           : request channel toward the DM (valid/ready)
//   dmi_resp_*          : response channel from the DM (valid/ready)
// ============================================================================
module dmi_xfer_ctrl #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dtm_update_i,
  input  logic [ADDR_WIDTH-1:0] dtm_addr_i,
  input  logic [DATA_WIDTH-1:0] dtm_data_i,
  input  logic [1:0]            dtm_op_i,
  input  logic                  dmireset_i,
  input  logic                  dmihardreset_i,
  output logic [ADDR_WIDTH-1:0] capture_addr_o,
  output logic [DATA_WIDTH-1:0] capture_data_o,
  output logic [1:0]            capture_op_o,
  output logic [1:0]            dmistat_o,
  output logic                  busy_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [ADDR_WIDTH-1:0] dmi_req_addr_o,
  output logic [DATA_WIDTH-1:0] dmi_req_data_o,
  output logic [1:0]            dmi_req_op_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [DATA_WIDTH-1:0] dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_resp_i
);

  // DMI op / response encodings (jtag_dmi_pkg values)
  localparam logic [1:0] c_OP_NOP       = 2'd0;
  localparam logic [1:0] c_OP_READ      = 2'd1;
  localparam logic [1:0] c_OP_WRITE     = 2'd2;
  localparam logic [1:0] c_OP_RSVD      = 2'd3;
  localparam logic [1:0] c_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] c_RESP_FAILED  = 2'd2;
  localparam logic [1:0] c_RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                r_state;
  logic [1:0]            r_sticky;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic [1:0]            r_req_op;
  logic [ADDR_WIDTH-1:0] r_capture_addr;
  logic [DATA_WIDTH-1:0] r_capture_data;

  logic w_req_hs;
  logic w_resp_hs;
  logic w_accept;
  logic w_timeout;

  assign w_req_hs  = (r_state == ST_REQ)  && dmi_req_ready_i;
  assign w_resp_hs = (r_state == ST_WAIT) && dmi_resp_valid_i;

  // A new request is only taken when idle, error-free and not masked by a
  // same-cycle dmireset.
  assign w_accept = dtm_update_i && !dmireset_i && (r_sticky == 2'd0) &&
                    (r_state == ST_IDLE) &&
                    ((dtm_op_i == c_OP_READ) || (dtm_op_i == c_OP_WRITE));

`ifdef DMI_XFER_TIMEOUT_EN
  localparam int c_TIMER_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_TIMER_W   = (c_TIMER_RAW < 8)  ? 8 :
                               (c_TIMER_RAW > 32) ? 32 : c_TIMER_RAW;
  // Fires on the cycle whose increment would reach TIMEOUT_CYCLES, so the
  // request/response phase lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [c_TIMER_W-1:0] r_timer;

  // Held at zero while idle, so it starts from zero on REQ entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (dmihardreset_i || (r_state == ST_IDLE)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // A handshake in the same cycle takes precedence over the timeout.
  assign w_timeout = (r_state != ST_IDLE) && (r_timer == c_TIMEOUT_LAST) &&
                     !w_req_hs && !w_resp_hs;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sticky       <= 2'd0;
      r_req_addr     <= '0;
      r_req_data     <= '0;
      r_req_op       <= c_OP_NOP;
      r_capture_addr <= '0;
      r_capture_data <= '0;
    end else if (dmihardreset_i) begin
      r_state        <= ST_IDLE;
      r_sticky       <= 2'd0;
      r_req_addr     <= '0;
      r_req_data     <= '0;
      r_req_op       <= c_OP_NOP;
      r_capture_addr <= '0;
      r_capture_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_addr     <= dtm_addr_i;
            r_req_data     <= dtm_data_i;
            r_req_op       <= dtm_op_i;
            r_capture_addr <= dtm_addr_i;
            r_state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_req_hs)       r_state <= ST_WAIT;
          else if (w_timeout) r_state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (w_resp_hs) begin
            r_state <= ST_IDLE;
            if (r_req_op == c_OP_READ) r_capture_data <= dmi_resp_data_i;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Sticky error: dmireset beats everything, then the first error wins
      // and holds until cleared. An error response outranks a same-cycle
      // update; a clean response still lets that update flag BUSY because
      // the registered state is not yet IDLE.
      if (dmireset_i) begin
        r_sticky <= 2'd0;
      end else if (r_sticky == 2'd0) begin
        if (w_resp_hs && (dmi_resp_resp_i != c_RESP_SUCCESS)) begin
          r_sticky <= c_RESP_FAILED;
        end else if (w_timeout) begin
          r_sticky <= c_RESP_FAILED;
        end else if (dtm_update_i) begin
          if (r_state != ST_IDLE)          r_sticky <= c_RESP_BUSY;
          else if (dtm_op_i == c_OP_RSVD)  r_sticky <= c_RESP_FAILED;
        end
      end
    end
  end

  assign busy_o           = (r_state != ST_IDLE);
  assign dmi_req_valid_o  = (r_state == ST_REQ);
  assign dmi_resp_ready_o = (r_state == ST_WAIT);
  assign dmi_req_addr_o   = r_req_addr;
  assign dmi_req_data_o   = r_req_data;
  assign dmi_req_op_o     = r_req_op;
  assign capture_addr_o   = r_capture_addr;
  assign capture_data_o   = r_capture_data;
  assign dmistat_o        = r_sticky;
  assign capture_op_o     = (r_sticky != 2'd0) ? r_sticky :
                            busy_o             ? c_RESP_BUSY : c_RESP_SUCCESS;

endmodule
`default_nettype wire

// File: tb/tb_dmi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_xfer_ctrl
// Purpose  : Directed self-checking bench for dmi_xfer_ctrl. The DM side is
//            driven by hand in each scenario task.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmi_xfer_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dtm_update = 1'b0;
  logic [AW-1:0] dtm_addr = '0;
  logic [DW-1:0] dtm_data = '0;
  logic [1:0]    dtm_op = 2'd0;
  logic          dmireset = 1'b0;
  logic          dmihardreset = 1'b0;
  logic [AW-1:0] capture_addr;
  logic [DW-1:0] capture_data;
  logic [1:0]    capture_op;
  logic [1:0]    dmistat;
  logic          busy;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [1:0]    req_op;
  logic          resp_valid = 1'b0;
  logic          resp_ready;
  logic [DW-1:0] resp_data = '0;
  logic [1:0]    resp_resp = 2'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmi_xfer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dtm_update_i(dtm_update), .dtm_addr_i(dtm_addr), .dtm_data_i(dtm_data),
    .dtm_op_i(dtm_op), .dmireset_i(dmireset), .dmihardreset_i(dmihardreset),
    .capture_addr_o(capture_addr), .capture_data_o(capture_data),
    .capture_op_o(capture_op), .dmistat_o(dmistat), .busy_o(busy),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_resp_i(resp_resp)
  );

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle Update-DR pulse and step past the edge that takes it.
  task automatic update(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dtm_op = op; dtm_addr = a; dtm_data = d; dtm_update = 1'b1;
    tick();
    dtm_update = 1'b0;
  endtask

  task automatic pulse_dmireset();
    dmireset = 1'b1; tick(); dmireset = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", req_valid); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", resp_ready); end
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL reset_dmistat got=%h exp=0", dmistat); end
    checks++; if (capture_op !== 2'd0) begin errors++; $display("FAIL reset_capop got=%h exp=0", capture_op); end
    checks++; if (capture_addr !== 7'h00) begin errors++; $display("FAIL reset_capaddr got=%h exp=0", capture_addr); end
    checks++; if (capture_data !== 32'h0) begin errors++; $display("FAIL reset_capdata got=%h exp=0", capture_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'hDEADBEEF; resp_resp = 2'd0;
    update(2'd1, 7'h11, 32'h0);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL read_valid_n1 got=%b exp=1", req_valid); end
    checks++; if (req_addr !== 7'h11) begin errors++; $display("FAIL read_req_addr got=%h exp=11", req_addr); end
    checks++; if (req_op !== 2'd1) begin errors++; $display("FAIL read_req_op got=%h exp=1", req_op); end
    checks++; if (capture_op !== 2'd3) begin errors++; $display("FAIL read_capop_busy got=%h exp=3", capture_op); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL read_valid_n2 got=%b exp=0", req_valid); end
    checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL read_ready_n2 got=%b exp=1", resp_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle_n3 got=%b exp=0", busy); end
    checks++; if (capture_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_capdata got=%h exp=deadbeef", capture_data); end
    checks++; if (capture_addr !== 7'h11) begin errors++; $display("FAIL read_capaddr got=%h exp=11", capture_addr); end
    checks++; if (capture_op !== 2'd0) begin errors++; $display("FAIL read_capop got=%h exp=0", capture_op); end
  endtask

  task automatic test_write_error();
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'hAAAA5555; resp_resp = 2'd2;
    update(2'd2, 7'h05, 32'h12345678);
    checks++; if (req_data !== 32'h12345678) begin errors++; $display("FAIL wr_req_data got=%h exp=12345678", req_data); end
    checks++; if (req_op !== 2'd2) begin errors++; $display("FAIL wr_req_op got=%h exp=2", req_op); end
    tick(); tick();
    checks++; if (dmistat !== 2'd2) begin errors++; $display("FAIL wr_dmistat got=%h exp=2", dmistat); end
    checks++; if (capture_op !== 2'd2) begin errors++; $display("FAIL wr_capop got=%h exp=2", capture_op); end
    checks++; if (capture_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_capdata_kept got=%h exp=deadbeef", capture_data); end
    update(2'd1, 7'h22, 32'h0);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL wr_sticky_ignore_valid got=%b exp=0", req_valid); end
    checks++; if (capture_addr !== 7'h05) begin errors++; $display("FAIL wr_sticky_ignore_addr got=%h exp=05", capture_addr); end
    pulse_dmireset();
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL wr_dmireset got=%h exp=0", dmistat); end
    resp_resp = 2'd0; resp_valid = 1'b0;
  endtask

  task automatic test_busy_update();
    req_ready = 1'b1; resp_valid = 1'b0;
    update(2'd1, 7'h33, 32'h0);
    tick();
    checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL busy_in_wait got=%b exp=1", resp_ready); end
    update(2'd1, 7'h44, 32'h0);
    checks++; if (dmistat !== 2'd3) begin errors++; $display("FAIL busy_dmistat got=%h exp=3", dmistat); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL busy_no_req got=%b exp=0", req_valid); end
    resp_valid = 1'b1; resp_data = 32'hCAFEF00D;
    tick();
    resp_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_done got=%b exp=0", busy); end
    checks++; if (capture_data !== 32'hCAFEF00D) begin errors++; $display("FAIL busy_capdata got=%h exp=cafef00d", capture_data); end
    checks++; if (capture_addr !== 7'h33) begin errors++; $display("FAIL busy_capaddr got=%h exp=33", capture_addr); end
    checks++; if (capture_op !== 2'd3) begin errors++; $display("FAIL busy_capop got=%h exp=3", capture_op); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL busy_no_second got=%b exp=0", req_valid); end
    pulse_dmireset();
  endtask

  task automatic test_resp_update_same_cycle();
    req_ready = 1'b1; resp_valid = 1'b0;
    update(2'd1, 7'h44, 32'h0);
    tick();
    resp_valid = 1'b1; resp_data = 32'h0BADCAFE;
    update(2'd1, 7'h55, 32'h0);
    resp_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_idle got=%b exp=0", busy); end
    checks++; if (dmistat !== 2'd3) begin errors++; $display("FAIL same_dmistat got=%h exp=3", dmistat); end
    checks++; if (capture_data !== 32'h0BADCAFE) begin errors++; $display("FAIL same_capdata got=%h exp=0badcafe", capture_data); end
    checks++; if (capture_addr !== 7'h44) begin errors++; $display("FAIL same_capaddr got=%h exp=44", capture_addr); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL same_no_req got=%b exp=0", req_valid); end
    pulse_dmireset();
  endtask

  task automatic test_rsvd_nop();
    update(2'd3, 7'h66, 32'h0);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rsvd_valid got=%b exp=0", req_valid); end
    checks++; if (dmistat !== 2'd2) begin errors++; $display("FAIL rsvd_dmistat got=%h exp=2", dmistat); end
    pulse_dmireset();
    update(2'd0, 7'h77, 32'h0);
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL nop_valid got=%b exp=0", req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy got=%b exp=0", busy); end
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL nop_dmistat got=%h exp=0", dmistat); end
    checks++; if (capture_addr !== 7'h44) begin errors++; $display("FAIL nop_capaddr got=%h exp=44", capture_addr); end
  endtask

  task automatic test_hardreset();
    req_ready = 1'b0;
    update(2'd2, 7'h7F, 32'h55AA55AA);
    tick();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL hr_valid_before got=%b exp=1", req_valid); end
    dmihardreset = 1'b1; tick(); dmihardreset = 1'b0;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL hr_valid got=%b exp=0", req_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hr_busy got=%b exp=0", busy); end
    checks++; if (capture_addr !== 7'h00) begin errors++; $display("FAIL hr_capaddr got=%h exp=0", capture_addr); end
    checks++; if (capture_data !== 32'h0) begin errors++; $display("FAIL hr_capdata got=%h exp=0", capture_data); end
    checks++; if (capture_op !== 2'd0) begin errors++; $display("FAIL hr_capop got=%h exp=0", capture_op); end
  endtask

  task automatic test_timeout();
    req_ready = 1'b0;
    update(2'd1, 7'h0A, 32'h0);
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL to_valid_start got=%b exp=1", req_valid); end
`ifdef DMI_XFER_TIMEOUT_EN
    repeat (TO - 1) tick();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL to_valid_hold got=%b exp=1", req_valid); end
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL to_valid_drop got=%b exp=0", req_valid); end
    checks++; if (dmistat !== 2'd2) begin errors++; $display("FAIL to_dmistat got=%h exp=2", dmistat); end
`else
    repeat (1000) tick();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL noto_valid got=%b exp=1", req_valid); end
    checks++; if (dmistat !== 2'd0) begin errors++; $display("FAIL noto_dmistat got=%h exp=0", dmistat); end
`endif
    dmihardreset = 1'b1; tick(); dmihardreset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_error();
    test_busy_update();
    test_resp_update_same_cycle();
    test_rsvd_nop();
    test_hardreset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
